div_iter: RTL and testbench

- Iterative radix-2 restoring divider for the pipelined CPU's EX stage. Serves DIV and DIVU.
- Takes operands from the forwarding muxes and produces quotient (LO) and remainder (HI).
- The HI/LO registers and the writeback result mux consume its results.
- Drives busy so the hazard logic can stall the front of the pipeline while a divide is in flight.

---
 rtl/div_iter.sv | 127 ++++++++++++
 tb/tb_div_iter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider (DIV/DIVU) for the EX stage
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] rem_q,    rem_d;     // running remainder (always < divisor)
    logic [WIDTH-1:0] quo_q,    quo_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvsr_q,   dvsr_d;    // divisor magnitude
    logic             neg_q_q,  neg_q_d;   // negate quotient at fix-up
    logic             neg_r_q,  neg_r_d;   // negate remainder at fix-up
    logic             div0_q,   div0_d;
    logic [WIDTH-1:0] quot_q,   quot_d;
    logic [WIDTH-1:0] remo_q,   remo_d;

    logic             a_neg, b_neg, accept, ge;
    logic [WIDTH:0]   shifted;             // WIDTH+1-bit partial remainder, keeps the carry

    assign a_neg  = is_signed & dividend[WIDTH-1];
    assign b_neg  = is_signed & divisor[WIDTH-1];
    assign accept = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

    // One restoring step: shift the next dividend bit in and trial-subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dvsr_q});

    // Next-state and datapath selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        div0_d  = div0_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        if (accept) begin
            state_d = S_RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_neg ? -dividend : dividend;
            dvsr_d  = b_neg ? -divisor : divisor;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            div0_d  = (divisor == '0);
        end else if (flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    rem_d = ge ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SIGN;
                    end
                end
                S_SIGN: begin
                    // A zero divisor gives all-ones quotient bits; the remainder path
                    // already reproduces the dividend (-|x| == x for negative x).
                    quot_d  = div0_q ? '1 : (neg_q_q ? -quo_q : quo_q);
                    remo_d  = neg_r_q ? -rem_q : rem_q;
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            div0_q  <= div0_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign busy      = (state_q == S_RUN) | (state_q == S_SIGN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed-vector self-checking bench for div_iter
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn, start, is_signed, flush;
    logic [W-1:0] dividend, divisor;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] prev_q, prev_r;

    div_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a divide now and return in the cycle where done is seen.
    // poke > 0 pulses start with junk operands in that busy cycle.
    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int poke, input string tag);
        int   lat;
        int   bcnt;
        logic stable;
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            if (busy && (quotient !== prev_q || remainder !== prev_r)) stable = 1'b0;
            if (i == poke) begin
                start     = 1'b1;
                dividend  = ~a;
                divisor   = 32'd3;
                is_signed = ~sgn;
            end
            tick;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, W'(lat), W'(W + 1));
        chk({tag, " busy_cycles"}, W'(bcnt), W'(W + 1));
        chk({tag, " stable"}, W'(stable), W'(1));
        chk({tag, " busy_at_done"}, W'(busy), W'(0));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic settle(input string tag);
        tick;
        chk({tag, " done_drop"}, W'(done), W'(0));
    endtask

    initial begin
        int dcnt;
        resetn = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0;
        prev_q = '0; prev_r = '0;
        tick;
        tick;
        chk("rst busy", W'(busy), W'(0));
        chk("rst done", W'(done), W'(0));
        chk("rst quotient", quotient, 32'h0);
        chk("rst remainder", remainder, 32'h0);
        resetn = 1'b1;
        tick;

        do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "u100_7");           settle("u100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "s-7_2"); settle("s-7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, "s7_-2"); settle("s7_-2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, "s_ovf"); settle("s_ovf");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 0, "u_max_1"); settle("u_max_1");
        do_div(1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 0, "u_top_3"); settle("u_top_3");
        do_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, "u_div0");     settle("u_div0");
        do_div(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, "s_div0");     settle("s_div0");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, "s_neg_div0"); settle("s_neg_div0");

        // Flush at RUN cycle 10, with a start in the same cycle that must be ignored.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        tick;
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        flush = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd5;
        tick;
        flush = 1'b0; start = 1'b0;
        chk("flush busy", W'(busy), W'(0));
        chk("flush done", W'(done), W'(0));
        chk("flush quotient", quotient, prev_q);
        chk("flush remainder", remainder, prev_r);
        do_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, "retry");       settle("retry");

        // start while busy is ignored.
        do_div(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 5, "poke");     settle("poke");

        // Reset in the middle of RUN.
        start = 1'b1; is_signed = 1'b1; dividend = 32'd999; divisor = 32'd9;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk("midrst busy", W'(busy), W'(0));
        chk("midrst done", W'(done), W'(0));
        chk("midrst quotient", quotient, 32'h0);
        chk("midrst remainder", remainder, 32'h0);
        prev_q = '0; prev_r = '0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done) dcnt++;
        end
        chk("midrst no_done", W'(dcnt), W'(0));

        // Back-to-back: the second start lands in the DONE cycle of the first.
        do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "b2b_a");
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, "b2b_b");
        settle("b2b_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
